crc8_framer_tx: RTL and testbench
=================================

Name: crc8_framer_tx

Overview:
- Transmit-side framing stage that feeds the CRC-8 link: accepts a byte stream with frame delimiters, forwards each payload byte, and appends the computed CRC-8 as the final beat of every frame.
- Uses the same CRC-8 algorithm as the CRC generator/checker (poly 0x07, LSB-first bit order), so the receive-side checker validates its output directly.
- Valid/ready on both sides, with a single registered output stage.

Parameters:
- POLY, 8'h07, CRC-8 generator polynomial (x^8+x^2+x+1).
- INIT, 8'h00, CRC register value at reset and at the start of each frame.
- MAX_LEN, 255, maximum payload bytes per frame (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream payload byte.
- s_last  in  1  marks the final payload byte of a frame.
- s_ready  out  1  block can accept a byte this cycle.
- m_valid  out  1  output beat valid.
- m_data  out  8  output byte (payload or CRC).
- m_last  out  1  high only on the CRC beat (end of frame).
- m_ready  in  1  downstream accepts the beat.
- err_len  out  1  one-cycle pulse when a frame is force-terminated at MAX_LEN.
- frames_sent  out  16  completed-frame counter; port present only with CRC8_FRAMER_STATS_EN.

Behaviour:
- One clock; reset is synchronous, active-high (clk, rst).
- Reset values: m_valid=0, m_data=0, m_last=0, err_len=0, frames_sent=0, crc=INIT, len=0, state=IDLE.
- CRC update per accepted byte d: for i=0..7 in order, fb=crc[7]^d[i]; crc=(crc<<1)^(fb?POLY:0). CRC is not reflected and not XORed on output.
- Slot free: slot_free = !m_valid || m_ready.
- s_ready = slot_free && state!=CRC. This is combinational from m_ready, with no combinational path from s_valid.
- Accept: s_valid && s_ready. On the next edge: m_data<=s_data, m_valid<=1, m_last<=0, crc<=update(crc,s_data), len<=len+1. Latency is 1 cycle from input to output.
- States:
  - IDLE: no byte of the current frame accepted yet. Accepting a byte goes to DATA, or to CRC if s_last is set.
  - DATA: accept with s_last goes to CRC. Accept when len==MAX_LEN-1 and !s_last also goes to CRC (force-terminate) and pulses err_len for 1 cycle.
  - CRC: s_ready=0. When slot_free: m_data<=crc (including the last payload byte), m_last<=1, m_valid<=1, crc<=INIT, len<=0, frames_sent+1, then go to IDLE.
- Output hold: while m_valid && !m_ready, m_data and m_last are held stable.
- Throughput: an N-byte frame takes N+1 output beats. With m_ready held high, s_ready is low for exactly 1 cycle after each last byte. Back-to-back frames otherwise have no bubble.
- Empty frames are not supported. A frame always has at least 1 payload byte, and s_last is only meaningful on an accepted beat.
- frames_sent wraps from 0xFFFF to 0x0000.
- Reset mid-frame: any partial frame is discarded, the output beat is dropped (m_valid=0), and the CRC returns to INIT. No CRC beat is emitted for the aborted frame.
- Bytes after a forced termination belong to a new frame, and err_len does not repeat for them.

Optional Feature:
- CRC8_FRAMER_STATS_EN defined: the 16-bit frames_sent port and its counter exist; the counter increments when the CRC beat is loaded into the output register.
- Macro undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Single byte 0x01 with s_last, m_ready=1 → beats 0x01 (m_last=0) then 0x89 (m_last=1); s_ready low 1 cycle after accept.
- Frame {0x00,0x01}, then immediately frame {0x00} → outputs 0x00,0x01,0x89(last),0x00,0x00(last). CRC resets to INIT between frames; frames_sent=2 with STATS_EN.
- Backpressure: frame {0x01}, m_ready=0 for 5 cycles → m_data=0x01 held stable, s_ready=0 throughout. After release, 0x01 then 0x89 are delivered with no loss or duplication.
- MAX_LEN=4, 6 bytes 0x00 with s_last only on byte 6 → beats 0,0,0,0,CRC 0x00(last) with err_len pulsed once. Then 0,0,CRC 0x00(last) as a new frame.
- rst asserted after 2 bytes of a 4-byte frame → next cycle m_valid=0. A new frame {0x01} then produces 0x01 and 0x89, confirming the CRC restarted from INIT.
- Random valid/ready toggling over 1000 frames against a reference model → every frame's CRC beat matches, and the receive-side checker reports crc_ok.

Source files
------------

// File: rtl/crc8_framer_tx.sv
// CRC-8 transmit framer: forwards payload bytes and appends the frame CRC beat.
// Optional frames_sent counter/port enabled by defining CRC8_FRAMER_STATS_EN.
module crc8_framer_tx #(
    parameter logic [7:0] POLY    = 8'h07,
    parameter logic [7:0] INIT    = 8'h00,
    parameter int         MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        err_len
`ifdef CRC8_FRAMER_STATS_EN
    ,
    output logic [15:0] frames_sent
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  len_q, len_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic        err_len_q, err_len_d;

    logic slot_free;
    logic accept;
    logic force_end;
    logic load_crc;

    // Data bits enter LSB-first; register shifts MSB-first, no reflection.
    function automatic logic [7:0] crc_upd(input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return r;
    endfunction

    assign slot_free = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign force_end = accept && !s_last && (len_q == LEN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    state_d = (s_last || force_end) ? CRC : DATA;
                end
            end
            CRC: begin
                if (slot_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = slot_free && (state_q != CRC);
        load_crc = slot_free && (state_q == CRC);
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_len_d = force_end;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_last_d  = 1'b0;
            crc_d     = crc_upd(crc_q, s_data);
            len_d     = len_q + 8'd1;
        end else if (load_crc) begin
            m_valid_d = 1'b1;
            m_data_d  = crc_q;
            m_last_d  = 1'b1;
            crc_d     = INIT;
            len_d     = 8'd0;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            crc_q     <= INIT;
            len_q     <= 8'd0;
            err_len_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            err_len_q <= err_len_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign err_len = err_len_q;

`ifdef CRC8_FRAMER_STATS_EN
    logic [15:0] frames_q, frames_d;

    always_comb begin
        frames_d = frames_q;
        if (load_crc) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= 16'h0000;
        end else begin
            frames_q <= frames_d;
        end
    end

    assign frames_sent = frames_q;
`endif

endmodule

// File: tb/tb_crc8_framer_tx.sv
// Scoreboard bench for crc8_framer_tx with a table-driven CRC-8 reference.
// Expected beats are queued on accept; a monitor pops them on each handshake.
module tb_crc8_framer_tx;

    localparam int MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        err_len;
`ifdef CRC8_FRAMER_STATS_EN
    logic [15:0] frames_sent;
`endif

    crc8_framer_tx #(
        .POLY(8'h07),
        .INIT(8'h00),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready),
        .err_len(err_len)
`ifdef CRC8_FRAMER_STATS_EN
        ,
        .frames_sent(frames_sent)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] tbl[256];
    logic [7:0] mcrc;
    int         mlen;
    int         merr;
    int         mframes;
    int         err_seen;
    int         rdy_mode;

    // Reference: crc' = T[crc ^ bitrev(d)], T[a] = a*x^8 mod (x^8+x^2+x+1).
    function automatic logic [7:0] bitrev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    task automatic build_table();
        logic [15:0] v;
        logic [15:0] p;
        for (int i = 0; i < 256; i++) begin
            v = 16'(i) << 8;
            for (int b = 15; b >= 8; b--) begin
                p = 16'h0107 << (b - 8);
                if (v[b]) v = v ^ p;
            end
            tbl[i] = v[7:0];
        end
    endtask

    task automatic model_reset();
        mcrc = 8'h00;
        mlen = 0;
        mframes = 0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        mcrc = tbl[mcrc ^ bitrev(d)];
        mlen++;
        exp_q.push_back({1'b0, d});
        if (l || mlen == MAX_LEN) begin
            exp_q.push_back({1'b1, mcrc});
            if (!l) merr++;
            mframes++;
            mcrc = 8'h00;
            mlen = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic       hold_prev = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;
    logic       err_prev = 1'b0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(hold_d));
                check("hold_last", int'(m_last), int'(hold_l));
            end
            if (m_valid && !m_ready) check("sready_stall", int'(s_ready), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h last=%0b, none expected",
                             m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(m_data), int'(e[7:0]));
                    check("beat_last", int'(m_last), int'(e[8]));
                end
            end
            if (err_len) begin
                err_seen++;
                check("err_len_width", int'(err_prev), 0);
            end
            hold_prev = m_valid && !m_ready;
            hold_d    = m_data;
            hold_l    = m_last;
            err_prev  = err_len;
        end else begin
            hold_prev = 1'b0;
            err_prev  = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        logic acc;
        int   n;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_ready in %0d cycles, required accept", n);
        end else begin
            model_accept(d, l);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string name);
`ifdef CRC8_FRAMER_STATS_EN
        check(name, int'(frames_sent), mframes & 16'hFFFF);
`else
        if (name.len() == 0) $display("empty stats name");
`endif
    endtask

    int e0;
    int len;

    initial begin
        build_table();
        model_reset();
        merr = 0;
        err_seen = 0;
        rdy_mode = 1;
        m_ready = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_err_len", int'(err_len), 0);
        check_stats("rst_frames");
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_byte(8'h01, 1'b1, 0);
        @(negedge clk);
        check("sready_after_last", int'(s_ready), 0);
        check("first_beat", int'(m_data), 8'h01);
        @(negedge clk);
        check("sready_recovers", int'(s_ready), 1);
        check("crc_beat_0x89", int'(m_data), 8'h89);
        check("crc_beat_last", int'(m_last), 1);
        drain();

        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        drain();
        check_stats("frames_after_b2b");

        rdy_mode = 0;
        send_byte(8'h01, 1'b1, 0);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", int'(m_valid), 1);
            check("bp_data", int'(m_data), 8'h01);
            check("bp_sready", int'(s_ready), 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        drain();

        e0 = err_seen;
        for (int i = 0; i < 6; i++) send_byte(8'h00, (i == 5), 0);
        drain();
        check("err_len_once", err_seen - e0, 1);

        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        rdy_mode = 0;
        @(negedge clk);
        check("pre_rst_held", int'(m_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", int'(m_valid), 0);
        exp_q.delete();
        model_reset();
        check_stats("rst_mid_frames");
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_byte(8'h01, 1'b1, 0);
        drain();

        rdy_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                send_byte(8'($urandom_range(0, 255)), (b == len - 1),
                          $urandom_range(0, 2));
            end
        end
        rdy_mode = 1;
        drain();
        check("err_len_total", err_seen, merr);
        check_stats("frames_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
